fetch_unit: RTL

Instruction fetch stage of the five-stage RV32I pipeline. It sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues one-outstanding-request fetches to instruction memory over a valid/ready request and valid response interface. It presents `instr_out`/`pc_out`/`pcplus4_out` plus a valid flag, which feed the IF/ID register's `instr_in`/`pc_in`/`pcplus4_in` inputs. Hazard-unit stalls and execute-stage branch/jump redirects are honoured here.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath width, canonical NOP and the
// fetch-stage state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding request at a
// time to instruction memory and holds a single registered output slot that
// feeds the IF/ID register. Execute-stage redirects override hazard stalls.
// Optional feature: define FETCH_MISALIGN_EN to get the misalign_o pulse on
// redirects whose target has nonzero low bits.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            fetch_valid,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pcplus4_out
`ifdef FETCH_MISALIGN_EN
    ,
    output logic            misalign_o
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [XLEN-1:0] pcplus4_q, pcplus4_d;
    logic            consumed;
    logic            slot_free;

    // Slot handshake with IF/ID and the request qualifier toward memory
    always_comb begin
        consumed       = fetch_valid_q & ~stall;
        slot_free      = ~fetch_valid_q | consumed;
        imem_req_valid = ~reset & (state_q == REQ) & slot_free & ~redirect_valid;
        imem_req_addr  = reset ? RESET_PC : pc_q;
    end

    // Next-state logic for FSM, PC and output slot; redirect wins over all
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        pcplus4_d     = pcplus4_q;

        // Slot drained by IF/ID; a same-cycle response below refills it
        if (consumed) begin
            fetch_valid_d = 1'b0;
            instr_d       = NOP_INSTR;
        end

        if (redirect_valid) begin
            pc_d          = {redirect_pc[XLEN-1:2], 2'b00};
            fetch_valid_d = 1'b0;
            instr_d       = NOP_INSTR;
            case (state_q)
                // A response arriving now is simply ignored; otherwise the
                // in-flight one must be swallowed later in DROP.
                WAIT:    state_d = imem_rsp_valid ? REQ : DROP;
                DROP:    state_d = DROP;
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                REQ: begin
                    if (imem_req_valid && imem_req_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    // Slot is guaranteed free: requests only issue when it is
                    if (imem_rsp_valid) begin
                        fetch_valid_d = 1'b1;
                        instr_d       = imem_rsp_data;
                        pc_out_d      = pc_q;
                        pcplus4_d     = pc_q + 32'd4;
                        pc_d          = pc_q + 32'd4;
                        state_d       = REQ;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    // State, PC and output slot registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= REQ;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            pc_out_q      <= '0;
            pcplus4_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            pcplus4_q     <= pcplus4_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign pcplus4_out = pcplus4_q;

`ifdef FETCH_MISALIGN_EN
    logic misalign_q;

    // One-cycle flag for any redirect target that is not word aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_valid & (redirect_pc[1:0] != 2'b00);
        end
    end

    assign misalign_o = misalign_q;
`else
    // Low target bits are dropped silently when the flag is not built in
    logic unused_redirect_lo;
    assign unused_redirect_lo = ^redirect_pc[1:0];
`endif

endmodule
